tt_um_top: RTL and testbench

TT_UM_TOP -- requirements
Module: tt_um_top

---
 rtl/tt_um_top.sv | 134 +++++++++++++
 tb/tb_tt_um_top.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_top.sv
// ---------------------------------------------------------------------------
// tt_um_top
//
// Purpose:
//   32-bit Galois LFSR pseudo-random source (x^32 + x^22 + x^2 + x + 1). It
//   has a seed-load path, a hold control, and a choice of two step rates:
//   every enabled cycle, or once per slow tick. A tick is CLK_HZ/10 cycles.
//
// Ports:
//   clk      in   1  sole clock, rising edge
//   rst_n    in   1  synchronous reset, ACTIVE-HIGH despite the name
//   ena      in   1  enable; 0 freezes the LFSR and the tick counter
//   ui_in    in   8  [0] mode (0 = every cycle, 1 = per tick)
//                    [1] seed load
//                    [2] hold
//                    [7:2] seed value
//   uio_in   in   8  unused
//   uo_out   out  8  lfsr[7:0]
//   uio_out  out  8  lfsr[15:8]
//   uio_oe   out  8  constant 8'hFF, all bidirectional pins are outputs
// ---------------------------------------------------------------------------
module tt_um_top #(
    parameter int CLK_HZ = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // If CLK_HZ is below 20, clamp the divider to 1 so that there is a tick
    // every cycle and the counter never has a zero width.
    localparam int TICK_DIV = (CLK_HZ / 10 > 1) ? (CLK_HZ / 10) : 1;
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [31:0]      LFSR_RESET = 32'hACE1_2468;
    localparam logic [31:0]      LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0]      LFSR_ESCAPE = 32'h0000_0001;

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    logic       mode_tick;
    logic       seed_load;
    logic       hold;
    logic [5:0] seed_val;

    assign mode_tick = ui_in[0];
    assign seed_load = ui_in[1];
    assign hold      = ui_in[2];
    assign seed_val  = ui_in[7:2];

    // Nothing reads the bidirectional inputs.
    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in};

    // -----------------------------------------------------------------------
    // Slow-step tick counter: free-running 0..TICK_DIV-1
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick;

    assign tick = (cnt_q == TICK_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // LFSR next state
    // -----------------------------------------------------------------------
    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic [31:0] lfsr_step;
    logic [31:0] lfsr_seed;
    logic        do_step;

    // Galois right-shift: the bit that falls off the bottom is fed back
    // into the tap positions.
    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

    // Only the low 6 bits come from the pins. The upper bits are fixed and
    // nonzero, so a loaded seed can never be the lock-up state.
    assign lfsr_seed = {LFSR_RESET[31:6], seed_val};

    assign do_step = !mode_tick || tick;

    // Priority: load > zero escape > hold > step > no change.
    // The all-zero state cannot be reached by stepping. The escape is only
    // there to recover from an upset, and it goes ahead of hold so that
    // holding cannot keep the register stuck at zero.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = lfsr_seed;
        end else if (lfsr_q == 32'h0) begin
            lfsr_d = LFSR_ESCAPE;
        end else if (hold) begin
            lfsr_d = lfsr_q;
        end else if (do_step) begin
            lfsr_d = lfsr_step;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            lfsr_q <= LFSR_RESET;
            cnt_q  <= '0;
        end else if (ena) begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs come straight from the register
    // -----------------------------------------------------------------------
    assign uo_out  = lfsr_q[7:0];
    assign uio_out = lfsr_q[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_top.sv
module tb_tt_um_top;

    localparam int CLK_HZ = 100;
    localparam int TICK_N = CLK_HZ / 10;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_lfsr;
    int          m_cnt;

    tt_um_top #(.CLK_HZ(CLK_HZ)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_step(input logic [31:0] v);
        logic [31:0] taps;
        taps = 32'h8020_0003;
        return (v >> 1) ^ (v[0] ? taps : 32'h0);
    endfunction

    // Reference model for one rising edge, using the inputs as they are now.
    task automatic model_edge();
        logic [31:0] seed;
        logic        tk;
        seed = 32'hACE1_2468;
        if (rst_n) begin
            m_lfsr = seed;
            m_cnt  = 0;
        end else if (ena) begin
            tk    = (m_cnt == TICK_N - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            if (ui_in[1])
                m_lfsr = {seed[31:6], ui_in[7:2]};
            else if (m_lfsr == 32'h0)
                m_lfsr = 32'h1;
            else if (ui_in[2])
                m_lfsr = m_lfsr;
            else if (!ui_in[0] || tk)
                m_lfsr = ref_step(m_lfsr);
        end
        exp_q.push_back(m_lfsr);
    endtask

    // Push the model's prediction, clock the DUT, then pop and compare.
    task automatic cycle();
        logic [31:0] e;
        model_edge();
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got no entry, required one entry");
        end else begin
            e = exp_q.pop_front();
            if ({uio_out, uo_out} !== e[15:0]) begin
                errors++;
                $display("FAIL scoreboard: got %h required %h", {uio_out, uo_out}, e[15:0]);
            end
        end
        checks++;
        if (uio_oe !== 8'hFF) begin
            errors++;
            $display("FAIL uio_oe: got %h required ff", uio_oe);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; ena = 1'b0; ui_in = 8'h00;
        cycle();
        cycle();
        checks++;
        if (uo_out !== 8'h68 || uio_out !== 8'h24 || uio_oe !== 8'hFF) begin
            errors++;
            $display("FAIL reset_values: got %h/%h/%h required 68/24/ff", uo_out, uio_out, uio_oe);
        end
    endtask

    task automatic test_step_sequence();
        logic [31:0] golden [4];
        golden[0] = 32'h5670_9234;
        golden[1] = 32'h2B38_491A;
        golden[2] = 32'h159C_248D;
        golden[3] = 32'h8AEE_1245;
        rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00;
        cycle();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if ({uio_out, uo_out} !== golden[i][15:0]) begin
                errors++;
                $display("FAIL step_%0d: got %h required %h", i, {uio_out, uo_out}, golden[i][15:0]);
            end
        end
    endtask

    task automatic test_load_hold();
        ui_in = 8'hAE;
        cycle();
        checks++;
        if ({uio_out, uo_out} !== 16'h246B) begin
            errors++;
            $display("FAIL load: got %h required 246b", {uio_out, uo_out});
        end
        ui_in = 8'h04;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if ({uio_out, uo_out} !== 16'h246B) begin
                errors++;
                $display("FAIL hold_%0d: got %h required 246b", i, {uio_out, uo_out});
            end
        end
    endtask

    task automatic test_tick_mode();
        logic [15:0] prev;
        logic        changed;
        rst_n = 1'b1; ena = 1'b1; ui_in = 8'h01;
        cycle();
        rst_n = 1'b0;
        prev = 16'h2468;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            changed = ({uio_out, uo_out} !== prev);
            checks++;
            if (changed !== (i % TICK_N == 0)) begin
                errors++;
                $display("FAIL tick_edge_%0d: got changed=%0b required %0b", i, changed, (i % TICK_N == 0));
            end
            if (i == TICK_N) begin
                checks++;
                if ({uio_out, uo_out} !== 16'h9234) begin
                    errors++;
                    $display("FAIL tick_first: got %h required 9234", {uio_out, uo_out});
                end
            end
            prev = {uio_out, uo_out};
        end
    endtask

    task automatic test_enable();
        logic [15:0] frozen;
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00;
        repeat (3) cycle();
        frozen = m_lfsr[15:0];
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if ({uio_out, uo_out} !== frozen) begin
                errors++;
                $display("FAIL ena_hold_%0d: got %h required %h", i, {uio_out, uo_out}, frozen);
            end
        end
        rst_n = 1'b1;
        cycle();
        checks++;
        if (uo_out !== 8'h68 || uio_out !== 8'h24) begin
            errors++;
            $display("FAIL reset_no_ena: got %h/%h required 68/24", uo_out, uio_out);
        end
    endtask

    task automatic test_reset_override();
        logic [7:0] modes [3];
        modes[0] = 8'hAE;
        modes[1] = 8'h04;
        modes[2] = 8'h01;
        for (int m = 0; m < 3; m++) begin
            rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00;
            repeat (2) cycle();
            rst_n = 1'b1; ui_in = modes[m];
            cycle();
            checks++;
            if ({uio_out, uo_out} !== 16'h2468) begin
                errors++;
                $display("FAIL reset_override_%0d: got %h required 2468", m, {uio_out, uo_out});
            end
        end
        rst_n = 1'b0;
    endtask

    task automatic test_free_run();
        rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00;
        cycle();
        rst_n = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            ena   = ($urandom_range(0, 9) != 0);
            ui_in = $urandom_range(0, 255);
            if ($urandom_range(0, 15) != 0) ui_in[1] = 1'b0;
            if ($urandom_range(0, 3) != 0)  ui_in[2] = 1'b0;
            cycle();
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        m_lfsr = 32'h0;
        m_cnt  = 0;
        test_reset();
        test_step_sequence();
        test_load_hold();
        test_tick_mode();
        test_enable();
        test_reset_override();
        test_free_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
